// File: rtl/result_ascii_formatter_pkg.sv
// Shared types and constants for the ASCII decimal result formatter.
// Also holds the digit-count helper used to reject undersized BCD registers.
package fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SKIP,
        ST_SIGN,
        ST_EMIT,
        ST_TERM
    } fmt_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // Decimal digits needed for 2^(width-1), the largest magnitude a signed
    // width-bit value can have; 0.30103 approximates log10(2).
    function automatic int bcd_digits(input int width);
        return ((width - 1) * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/result_ascii_formatter_if.sv
// Value-in / character-out handshake bundle of the ASCII formatter.
// Both channels are valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the sender holds payload and valid stable
// until that edge, and the receiver may raise or drop ready at any time.
interface result_ascii_formatter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_value;
    logic             in_ready;
    logic [7:0]       char_data;
    logic             char_valid;
    logic             char_ready;
    logic             char_last;

    modport master (
        output in_valid, in_value, char_ready,
        input  in_ready, char_data, char_valid, char_last
    );

    modport slave (
        input  in_valid, in_value, char_ready,
        output in_ready, char_data, char_valid, char_last
    );
endinterface

// File: rtl/result_ascii_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH cycles.
// done is high during the final step and bcd then shows that step's result.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int NW = $clog2(WIDTH + 1);

    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    step;
    logic [WIDTH-1:0] mag_q;
    logic [NW-1:0]    cnt_q;
    logic             run_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
        end
        step = (adj << 1) | BW'(mag_q[WIDTH-1]);
    end

    assign done = run_q && (cnt_q == NW'(1));
    assign bcd  = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bcd_q <= '0;
            mag_q <= value;
            cnt_q <= NW'(WIDTH);
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= step;
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q - NW'(1);
            if (cnt_q == NW'(1)) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/result_ascii_formatter.sv
// Streams a signed result as ASCII decimal: optional '-', digits without
// leading zeros, then an optional terminator byte.
module result_ascii_formatter
    import fmt_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         DIGITS     = 10,
    parameter logic [7:0] TERMINATOR = 8'h00
) (
    input  logic                           clk,
    input  logic                           rst,
    result_ascii_formatter_if.slave        bus,
    output logic                           busy,
    output fmt_state_t                     fsm_state
);
    localparam int BW       = 4 * DIGITS;
    localparam int CW       = $clog2(DIGITS + 1);
    localparam bit HAS_TERM = (TERMINATOR != 8'h00);

    if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
        $error("DIGITS too small for WIDTH");
    end

    fmt_state_t       state_q, state_n;
    logic             neg_q, neg_n;
    logic [BW-1:0]    bcd_q, bcd_n, bcd_shift;
    logic [CW-1:0]    remain_q, remain_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             last_q, last_n;
    logic             ready_q, ready_n;
    logic             start;
    logic [WIDTH-1:0] mag;
    logic             conv_done;
    logic [BW-1:0]    conv_bcd;
    logic [3:0]       top_nib, next_nib;

    // Two's-complement negate; the most negative input maps to 2^(WIDTH-1).
    assign mag = bus.in_value[WIDTH-1] ? (~bus.in_value) + WIDTH'(1) : bus.in_value;

    assign bcd_shift = bcd_q << 4;
    assign top_nib   = bcd_q[BW-1 -: 4];
    assign next_nib  = bcd_shift[BW-1 -: 4];

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (mag),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_n  = state_q;
        neg_n    = neg_q;
        bcd_n    = bcd_q;
        remain_n = remain_q;
        data_n   = data_q;
        valid_n  = valid_q;
        last_n   = last_q;
        ready_n  = ready_q;
        start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_n = 1'b1;
                if (bus.in_valid && ready_q) begin
                    start    = 1'b1;
                    neg_n    = bus.in_value[WIDTH-1];
                    remain_n = CW'(DIGITS);
                    ready_n  = 1'b0;
                    state_n  = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    bcd_n   = conv_bcd;
                    state_n = ST_SKIP;
                end
            end
            ST_SKIP: begin
                // The last digit is never skipped, so zero still prints "0".
                if (top_nib == 4'd0 && remain_q > CW'(1)) begin
                    bcd_n    = bcd_shift;
                    remain_n = remain_q - CW'(1);
                end else if (neg_q) begin
                    state_n = ST_SIGN;
                    data_n  = ASCII_MINUS;
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                end else begin
                    state_n = ST_EMIT;
                    data_n  = ASCII_ZERO + {4'h0, top_nib};
                    valid_n = 1'b1;
                    last_n  = (remain_q == CW'(1)) && !HAS_TERM;
                end
            end
            ST_SIGN: begin
                if (bus.char_ready) begin
                    state_n = ST_EMIT;
                    data_n  = ASCII_ZERO + {4'h0, top_nib};
                    last_n  = (remain_q == CW'(1)) && !HAS_TERM;
                end
            end
            ST_EMIT: begin
                if (bus.char_ready) begin
                    bcd_n    = bcd_shift;
                    remain_n = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        if (HAS_TERM) begin
                            state_n = ST_TERM;
                            data_n  = TERMINATOR;
                            last_n  = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            ready_n = 1'b1;
                        end
                    end else begin
                        data_n = ASCII_ZERO + {4'h0, next_nib};
                        last_n = (remain_q == CW'(2)) && !HAS_TERM;
                    end
                end
            end
            ST_TERM: begin
                if (bus.char_ready) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
                ready_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            neg_q    <= 1'b0;
            bcd_q    <= '0;
            remain_q <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            neg_q    <= neg_n;
            bcd_q    <= bcd_n;
            remain_q <= remain_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            last_q   <= last_n;
            ready_q  <= ready_n;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.char_data  = data_q;
    assign bus.char_valid = valid_q;
    assign bus.char_last  = last_q;
    assign busy           = (state_q != ST_IDLE);
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_result_ascii_formatter.sv
// Directed bench: a no-terminator formatter (a) and a newline-terminated one (b)
// with byte-level scoreboards, latency, stall, ignore and reset checks.
module tb_result_ascii_formatter;
    import fmt_pkg::*;

    localparam int W = 9;

    logic clk;
    logic rst;
    logic busy_a, busy_b;
    fmt_state_t state_a, state_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cap_a[$];
    logic [W-1:0] cap_b[$];
    int           cyc_a[$];
    int           cyc_b[$];

    result_ascii_formatter_if #(.WIDTH(32)) bus_a ();
    result_ascii_formatter_if #(.WIDTH(32)) bus_b ();

    result_ascii_formatter #(
        .WIDTH(32), .DIGITS(10), .TERMINATOR(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .fsm_state(state_a)
    );

    result_ascii_formatter #(
        .WIDTH(32), .DIGITS(10), .TERMINATOR(8'h0A)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .fsm_state(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture every accepted byte with its cycle stamp
    always @(negedge clk) begin
        if (!rst && bus_a.char_valid && bus_a.char_ready) begin
            cap_a.push_back({bus_a.char_last, bus_a.char_data});
            cyc_a.push_back(cyc);
        end
        if (!rst && bus_b.char_valid && bus_b.char_ready) begin
            cap_b.push_back({bus_b.char_last, bus_b.char_data});
            cyc_b.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_str(input string s, input logic [7:0] term);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back({(i == s.len() - 1) && (term == 8'h00), s[i]});
        if (term != 8'h00) exp_q.push_back({1'b1, term});
    endtask

    task automatic send(input bit sel_b, input logic [31:0] v);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 500) begin
            @(posedge clk);
            #1;
            rdy = sel_b ? bus_b.in_ready : bus_a.in_ready;
            n++;
        end
        check("send_in_ready", {31'd0, rdy}, 32'd1);
        if (sel_b) begin bus_b.in_valid = 1'b1; bus_b.in_value = v; end
        else       begin bus_a.in_valid = 1'b1; bus_a.in_value = v; end
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic drain(input bit sel_b, input string tag, input bit gap_chk);
        int n, waited, prev, c;
        logic [W-1:0] got, exp;
        n = exp_q.size();
        waited = 0;
        prev = 0;
        while (((sel_b ? cap_b.size() : cap_a.size()) < n) && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        check({tag, "_count"}, sel_b ? cap_b.size() : cap_a.size(), n);
        #1;
        for (int i = 0; i < n; i++) begin
            got = 'x;
            c = 0;
            if (sel_b && cap_b.size() > 0) begin got = cap_b.pop_front(); c = cyc_b.pop_front(); end
            if (!sel_b && cap_a.size() > 0) begin got = cap_a.pop_front(); c = cyc_a.pop_front(); end
            exp = exp_q.pop_front();
            check({tag, "_byte"}, {23'd0, got}, {23'd0, exp});
            if (gap_chk && i > 0) check({tag, "_gap"}, c - prev, 1);
            prev = c;
        end
        check({tag, "_in_ready"}, {31'd0, sel_b ? bus_b.in_ready : bus_a.in_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, sel_b ? busy_b : busy_a}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] sb [3];
        logic       sl [3];
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_value = '0; bus_a.char_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_value = '0; bus_b.char_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        check("rst_char_valid", {31'd0, bus_a.char_valid}, 32'd0);
        check("rst_char_last", {31'd0, bus_a.char_last}, 32'd0);
        check("rst_char_data", {24'd0, bus_a.char_data}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_state", 32'(state_a), 32'(ST_IDLE));
        check("rst_in_ready_b", {31'd0, bus_b.in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", {31'd0, bus_a.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_rise", {31'd0, bus_a.in_ready}, 32'd1);

        exp_str("0", 8'h00);
        send(0, 32'd0);
        drain(0, "zero", 1);

        exp_str("12345", 8'h00);
        send(0, 32'd12345);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus_a.char_valid) break;
        end
        check("latency_12345", lat, 39);
        drain(0, "d12345", 1);

        exp_str("-7", 8'h00);
        send(0, 32'hFFFF_FFF9);
        drain(0, "neg7", 1);

        exp_str("-2147483648", 8'h00);
        send(0, 32'h8000_0000);
        drain(0, "min", 1);

        exp_str("2147483647", 8'h00);
        send(0, 32'h7FFF_FFFF);
        drain(0, "max", 1);

        // stalled consumer on the terminated instance, stray in_valid mid-stream
        sb[0] = 8'h34; sb[1] = 8'h32; sb[2] = 8'h0A;
        sl[0] = 1'b0;  sl[1] = 1'b0;  sl[2] = 1'b1;
        bus_b.char_ready = 1'b0;
        exp_str("42", 8'h0A);
        send(1, 32'd42);
        lat = 0;
        while (!bus_b.char_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                check("stall_data", {24'd0, bus_b.char_data}, {24'd0, sb[k]});
                check("stall_valid", {31'd0, bus_b.char_valid}, 32'd1);
                check("stall_last", {31'd0, bus_b.char_last}, {31'd0, sl[k]});
                @(posedge clk);
                #1;
                bus_b.in_valid = (k == 0 && s == 0);
                bus_b.in_value = 32'd99;
            end
            bus_b.in_valid = 1'b0;
            bus_b.char_ready = 1'b1;
            @(posedge clk);
            #1 bus_b.char_ready = 1'b0;
        end
        drain(1, "term42", 0);
        repeat (60) @(posedge clk);
        check("stray_ignored", cap_b.size(), 0);

        // reset in the middle of a string
        send(0, 32'd98765);
        lat = 0;
        while (!bus_a.char_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, bus_a.char_valid}, 32'd0);
        check("midrst_data", {24'd0, bus_a.char_data}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        @(posedge clk);
        cap_a.delete();
        cyc_a.delete();
        #1 rst = 1'b0;
        exp_str("5", 8'h00);
        send(0, 32'd5);
        drain(0, "after_rst", 1);
        repeat (50) @(posedge clk);
        check("after_rst_extra", cap_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_ascii_formatter.md
# result_ascii_formatter

Downstream stage of the expression evaluator. Takes the evaluator's `WIDTH`-bit two's-complement result and streams it out as ASCII decimal characters over a valid/ready byte interface. It feeds a UART transmitter or a display buffer. It converts sequentially by double-dabble, suppresses leading zeros, emits a `-` for negative values, and can append an optional terminator byte.

## Interface
Parameters:
- `WIDTH`, 32: width of the input result. Interpreted as signed two's complement.
- `DIGITS`, 10: number of BCD digits held. Must satisfy 10^DIGITS ≥ 2^(WIDTH-1).
- `TERMINATOR`, 8'h00: byte appended after the last digit. 8'h00 means no terminator.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_value` holds a result to format.
- `in_value`  in  `WIDTH`  signed result from the evaluator.
- `in_ready`  out  1  block can accept a value. Registered; high only in IDLE.
- `char_data`  out  8  ASCII byte.
- `char_valid`  out  1  `char_data` is valid.
- `char_ready`  in  1  consumer takes the byte when `char_valid && char_ready`.
- `char_last`  out  1  marks the final byte of the string; qualified by `char_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE → CONVERT → SKIP → SIGN → EMIT → TERM → IDLE.
  - SIGN is entered only for negative values.
  - TERM is entered only when `TERMINATOR != 0`.
- **IDLE:**
  - On `in_valid && in_ready`, latch `neg = in_value[WIDTH-1]`.
  - Latch `mag = neg ? -in_value : in_value` as unsigned `WIDTH` bits. The most negative value gives 2^(WIDTH-1) correctly.
  - Clear the BCD register (4·`DIGITS` bits) and go to CONVERT.
- **CONVERT:** runs exactly `WIDTH` cycles. Each cycle:
  - add 3 to every BCD nibble ≥ 5;
  - then shift {bcd, mag} left by 1.
- **SKIP:** one cycle per evaluated digit.
  - If the top nibble is 0 and more than 1 digit remains: shift the BCD register left by 4, decrement the remaining count, and stay in SKIP.
  - Otherwise go to SIGN if `neg`, else EMIT.
  - Zero therefore emits exactly one `"0"`.
- **SIGN:** present 8'h2D (`-`) and hold it until the byte is taken, then go to EMIT.
- **EMIT:** present `"0" + top nibble`.
  - On handshake, shift BCD left by 4 and decrement the count.
  - After the last digit, go to TERM, or go to IDLE when there is no terminator.
- **TERM:** present `TERMINATOR` and hold it until taken, then go to IDLE.
- `char_last` is high on the terminator when one is configured, otherwise on the final digit.
- `in_valid` outside IDLE is ignored and no value is captured.

## Timing
- Reset values: `in_ready`=0, `char_valid`=0, `char_last`=0, `char_data`=8'h00, `busy`=0. State is IDLE.
- `in_ready` rises on the first clock edge after `rst` deasserts.
- Latency:
  - Accept edge, then `WIDTH` CONVERT cycles, then z+1 SKIP cycles (z = leading zeros skipped).
  - `char_valid` rises in the following cycle.
  - For 32-bit 12345: z=5, so the first byte is valid 39 cycles after the accept edge.
- Output handshake:
  - `char_data`, `char_valid` and `char_last` are registered.
  - While `char_valid && !char_ready`, all three hold stable.
  - With `char_ready` held high, throughput is one byte per cycle, with no bubbles between bytes.
- `in_ready` returns high in the cycle after the final byte's handshake. The next value can be accepted on that edge.
- `rst` mid-operation: outputs return to their reset values immediately and asynchronously. The partial string is abandoned and never resumed.

## Structure
- Package `fmt_pkg`:
  - state enum `fmt_state_t`;
  - ASCII constants `ASCII_ZERO`=8'h30 and `ASCII_MINUS`=8'h2D;
  - function `bcd_digits(width)` for the `DIGITS` legality check (elaboration-time assertion).
- Sub-module `bin2bcd_seq`: a start/done double-dabble converter parameterised by `WIDTH` and `DIGITS`, taking exactly `WIDTH` cycles. The FSM, zero skip and emission stay in the top module.

## Test plan
- `in_value`=0, `char_ready`=1 → single byte 8'h30 with `char_last`=1; `in_ready` high again next cycle.
- 12345 → 31,32,33,34,35 (hex), on consecutive cycles; `char_last` only on 35.
- −7 (32'hFFFFFFF9) → 2D, 37; `char_last` on 37.
- 32'h80000000 → "-2147483648", 11 bytes; `DIGITS`=10 suffices.
- 42 with `char_ready` low for 3 cycles at each byte → `char_data`=34 held stable for those cycles. `in_valid` pulsed mid-stream is ignored. With `TERMINATOR`=8'h0A the output is 34, 32, 0A, with `char_last` on 0A.
- `rst` asserted during EMIT of 98765 → `char_valid`=0 immediately. A new value 5 after reset yields exactly 35.
